ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the result and target data width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream execute stage presents an operation.
REQ-005 SHALL have port in_ready, output, 1 bit: stage can accept; registered, equals occupancy<2.
REQ-006 SHALL have port ALUResult, input, XLEN bits: ALU output.
REQ-007 SHALL have port GES, input, 3 bits: compare flags; bit2 greater, bit1 equal, bit0 smaller.
REQ-008 SHALL have port Rd, input, 5 bits: destination register.
REQ-009 SHALL have port RegWrite, input, 1 bit: operation writes Rd.
REQ-010 SHALL have port Branch, input, 1 bit: operation is a conditional branch.
REQ-011 SHALL have port BrFunct, input, 3 bits: branch condition code.
REQ-012 SHALL have port BrTarget, input, XLEN bits: taken-branch target PC.
REQ-013 SHALL have port Flush, input, 1 bit: discard all buffered and incoming work.
REQ-014 SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts head.
REQ-016 SHALL have ports Out_Result (XLEN), Out_Rd (5), Out_RegWrite (1), outputs: head entry fields.
REQ-017 SHALL have port Redirect, output, 1 bit: one-cycle taken-branch pulse.
REQ-018 SHALL have port RedirectPC, output, XLEN bits: target qualified by Redirect.

Function
REQ-019 SHALL hold a 2-entry in-order buffer with occupancy states EMPTY, ONE, TWO.
REQ-020 SHALL accept an operation when in_valid & in_ready & ~Flush.
REQ-021 SHALL store accepted non-branch operations at the tail; Out_RegWrite SHALL be forced 0 when Rd==0.
REQ-022 SHALL NOT store accepted branch operations; they consume no buffer slot.
REQ-023 SHALL resolve taken at accept: 000 E; 001 ~E; 100/110 S; 101/111 G|E; 010/011 never taken.
REQ-024 SHALL assert Redirect for exactly the cycle after accepting a taken branch, RedirectPC = BrTarget registered.
REQ-025 SHALL pop the head when out_valid & out_ready; entry 2 SHALL shift to head the same edge.
REQ-026 Transitions: EMPTY->ONE on push; ONE->TWO push without pop; ONE->EMPTY pop without push; ONE stays on push+pop; TWO->ONE on pop.
REQ-027 In TWO, in_ready SHALL be 0 the whole cycle; a pop there SHALL raise in_ready on the next cycle only.
REQ-028 Push+pop in ONE SHALL present the new entry at head next cycle with no bubble.
REQ-029 out_valid SHALL be 1 exactly when occupancy>0; head fields SHALL be stable while out_valid & ~out_ready.
REQ-030 Flush SHALL set occupancy EMPTY next cycle, ignore same-cycle accept, suppress same-cycle Redirect generation.
REQ-031 Flush coincident with a pop SHALL still count as the pop downstream; result EMPTY.
REQ-032 Latency in->out SHALL be one cycle for non-branch operations into an empty stage.

Reset
REQ-033 rst high at a clock edge SHALL force EMPTY, out_valid=0, in_ready=1, Redirect=0, RedirectPC=0, Out_Result=0, Out_Rd=0, Out_RegWrite=0.
REQ-034 rst SHALL take priority over Flush, push and pop in the same cycle, including mid-operation in TWO.

Verification
REQ-035 Push ALUResult=0x1234, Rd=5, RegWrite=1, out_ready=1 -> next cycle out_valid=1, Out_Result=0x1234, Out_Rd=5.
REQ-036 Branch BrFunct=100, GES=001, BrTarget=0x80 -> Redirect=1 one cycle, RedirectPC=0x80, out_valid stays 0.
REQ-037 Branch BrFunct=000, GES=100, then BrFunct=011, GES=010 -> Redirect never asserted.
REQ-038 out_ready=0, push A,B -> in_ready=0; push C held; out_ready=1 -> A,B,C delivered in order, none lost.
REQ-039 TWO full, assert Flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming op discarded.
REQ-040 Push Rd=0, RegWrite=1 -> Out_RegWrite=0; rst asserted in TWO -> all outputs at REQ-033 values next cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry in-order result buffer; branches resolve at accept and redirect without using a slot.
// Latency 1 cycle in->out; in_ready is registered and drops while both entries are full.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [2:0]      GES,
  input  logic [4:0]      Rd,
  input  logic            RegWrite,
  input  logic            Branch,
  input  logic [2:0]      BrFunct,
  input  logic [XLEN-1:0] BrTarget,
  input  logic            Flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Out_Result,
  output logic [4:0]      Out_Rd,
  output logic            Out_RegWrite,
  output logic            Redirect,
  output logic [XLEN-1:0] RedirectPC
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            reg_write;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e   state;
  entry_t head;
  entry_t second;
  entry_t new_entry;
  logic   accept;
  logic   push;
  logic   pop;
  logic   taken;

  assign accept    = in_valid & in_ready & ~Flush;
  assign push      = accept & ~Branch;
  assign pop       = out_valid & out_ready;
  // Writes to x0 are architecturally dead, so drop the write enable here once.
  assign new_entry = '{result: ALUResult, rd: Rd, reg_write: RegWrite & (Rd != 5'd0)};

  // GES = {greater, equal, smaller}
  always_comb begin
    taken = 1'b0;
    case (BrFunct)
      3'b000:         taken = GES[1];
      3'b001:         taken = ~GES[1];
      3'b100, 3'b110: taken = GES[0];
      3'b101, 3'b111: taken = GES[2] | GES[1];
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      head       <= '0;
      second     <= '0;
      Redirect   <= 1'b0;
      RedirectPC <= '0;
    end else if (Flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      Redirect <= 1'b0;
    end else begin
      Redirect <= accept & Branch & taken;
      if (accept & Branch & taken)
        RedirectPC <= BrTarget;
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= new_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= new_entry;
          end else if (push) begin
            second   <= new_entry;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so no push can arrive alongside the pop.
          if (pop) begin
            head     <= second;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid    = (state != EMPTY);
  assign Out_Result   = head.result;
  assign Out_Rd       = head.rd;
  assign Out_RegWrite = head.reg_write;

endmodule
